// File: rtl/perm_lane_tx.sv
// Lane-stream transmitter: buffers 25-lane Keccak blocks from a load port and replays them with firstout on lane 0.
// Define PERM_TX_PINGPONG_EN for two banks (fill one while sending the other); the default build has a single bank.
module perm_lane_tx #(
  parameter int W     = 64,
  parameter int LANES = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_push,
  input  logic [W-1:0] ld_data,
  output logic         ld_stop,
  output logic         pushout,
  output logic         firstout,
  output logic [W-1:0] dout,
  input  logic         stopout,
  output logic         blk_sent,
  output logic         busy
);

`ifdef PERM_TX_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_SENDING} bank_t;
  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic nxt_bank(input logic b);
    if (NB > 1) return ~b;
    return 1'b0;
  endfunction

  logic [W-1:0] mem [NB][LANES];

  state_t        state, state_nxt;
  bank_t         bstate [NB];
  bank_t         bstate_nxt [NB];
  logic [CW-1:0] wcnt, wcnt_nxt, rcnt, rcnt_nxt;
  logic          wbank, wbank_nxt, rbank, rbank_nxt;
  logic          pushout_nxt, firstout_nxt, ld_stop_nxt;
  logic [W-1:0]  dout_nxt;
  logic          acc, fill_done, xfer, last_xfer, start, start_bank;
  logic [NB-1:0] avail;

  // Lane buffer: data only, never reset
  always_ff @(posedge clk) begin
    if (acc) mem[wbank][wcnt] <= ld_data;
  end

  always_comb begin
    acc       = ld_push & ~ld_stop;
    fill_done = acc && (wcnt == LAST);
    xfer      = pushout & ~stopout;
    last_xfer = xfer && (rcnt == LAST);

    // A bank completing its fill on this edge counts as FULL so sending starts without a bubble
    avail = '0;
    for (int b = 0; b < NB; b++)
      avail[b] = (bstate[b] == B_FULL) || (fill_done && (wbank == 1'(b)));

    state_nxt    = state;
    rbank_nxt    = rbank;
    rcnt_nxt     = rcnt;
    pushout_nxt  = pushout;
    firstout_nxt = firstout;
    dout_nxt     = dout;
    start        = 1'b0;
    start_bank   = rbank;

    case (state)
      S_IDLE: begin
        if (avail[rbank]) begin
          start      = 1'b1;
          start_bank = rbank;
        end
      end
      S_SEND: begin
        if (last_xfer) begin
          rbank_nxt = nxt_bank(rbank);
          if (avail[nxt_bank(rbank)]) begin
            start      = 1'b1;
            start_bank = nxt_bank(rbank);
          end else begin
            state_nxt    = S_IDLE;
            pushout_nxt  = 1'b0;
            firstout_nxt = 1'b0;
          end
        end else if (xfer) begin
          rcnt_nxt     = rcnt + 1'b1;
          firstout_nxt = 1'b0;
          dout_nxt     = mem[rbank][rcnt + 1'b1];
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (start) begin
      state_nxt    = S_SEND;
      rbank_nxt    = start_bank;
      rcnt_nxt     = '0;
      pushout_nxt  = 1'b1;
      firstout_nxt = 1'b1;
      dout_nxt     = mem[start_bank][0];
    end

    for (int b = 0; b < NB; b++) begin
      bstate_nxt[b] = bstate[b];
      if (start && (start_bank == 1'(b)))
        bstate_nxt[b] = B_SENDING;
      else if (last_xfer && (rbank == 1'(b)))
        bstate_nxt[b] = B_EMPTY;
      else if (fill_done && (wbank == 1'(b)))
        bstate_nxt[b] = B_FULL;
      else if (acc && (wbank == 1'(b)))
        bstate_nxt[b] = B_FILLING;
    end

    wcnt_nxt  = wcnt;
    wbank_nxt = wbank;
    if (fill_done) begin
      wcnt_nxt  = '0;
      wbank_nxt = nxt_bank(wbank);
    end else if (acc) begin
      wcnt_nxt = wcnt + 1'b1;
    end

    // Stop loading while the bank to be filled next still holds an unsent block
    ld_stop_nxt = (bstate_nxt[wbank_nxt] == B_FULL) || (bstate_nxt[wbank_nxt] == B_SENDING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      wbank    <= 1'b0;
      rcnt     <= '0;
      rbank    <= 1'b0;
      pushout  <= 1'b0;
      firstout <= 1'b0;
      dout     <= '0;
      ld_stop  <= 1'b0;
      blk_sent <= 1'b0;
      for (int b = 0; b < NB; b++) bstate[b] <= B_EMPTY;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      wbank    <= wbank_nxt;
      rcnt     <= rcnt_nxt;
      rbank    <= rbank_nxt;
      pushout  <= pushout_nxt;
      firstout <= firstout_nxt;
      dout     <= dout_nxt;
      ld_stop  <= ld_stop_nxt;
      blk_sent <= last_xfer;
      for (int b = 0; b < NB; b++) bstate[b] <= bstate_nxt[b];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int b = 0; b < NB; b++)
      if (bstate[b] != B_EMPTY) busy = 1'b1;
  end

endmodule

// File: tb/tb_perm_lane_tx.sv
// Bench for perm_lane_tx: the output stream must equal the accepted lane stream, in order, grouped in blocks of 25.
module tb_perm_lane_tx;
  logic        clk = 1'b0;
  logic        rst, ld_push, stopout;
  logic [63:0] ld_data;
  logic        ld_stop, pushout, firstout, blk_sent, busy;
  logic [63:0] dout;

  perm_lane_tx dut (
    .clk(clk), .rst(rst), .ld_push(ld_push), .ld_data(ld_data), .ld_stop(ld_stop),
    .pushout(pushout), .firstout(firstout), .dout(dout), .stopout(stopout),
    .blk_sent(blk_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  int npass = 0, ntotal = 0, cyc = 0, nsent = 0;
  logic [63:0] exp_q[$], got_d[$];
  bit          got_f[$];
  int          acc_cyc[$], got_cyc[$];

  task automatic clear_model();
    exp_q.delete(); got_d.delete(); got_f.delete();
    acc_cyc.delete(); got_cyc.delete(); nsent = 0;
  endtask

  // Record what happens on the coming edge, then advance to the next falling edge
  task automatic tick();
    if (ld_push && !ld_stop) begin exp_q.push_back(ld_data); acc_cyc.push_back(cyc); end
    if (pushout && !stopout) begin
      got_d.push_back(dout); got_f.push_back(firstout); got_cyc.push_back(cyc);
    end
    @(posedge clk); cyc++;
    @(negedge clk);
    if (blk_sent) nsent++;
  endtask

  task automatic drain(input int n);
    int g = 0;
    ld_push = 1'b0;
    while (got_d.size() < n && g < 400) begin tick(); g++; end
  endtask

  task automatic test_reset();
    ld_push = 0; stopout = 0; ld_data = '0; rst = 0;
    @(negedge clk); #2 rst = 1; #1;
    ntotal++;
    if ({pushout, firstout, ld_stop, blk_sent, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {pushout, firstout, ld_stop, blk_sent, busy});
    else npass++;
    ntotal++;
    if (dout !== 64'h0) $display("FAIL reset_dout: got %h expected 0", dout); else npass++;
    @(negedge clk); rst = 0; clear_model();
    for (int i = 0; i < 10; i++) begin
      tick();
      ntotal++;
      if (pushout !== 1'b0) $display("FAIL idle_pushout: cycle %0d got %b expected 0", i, pushout);
      else npass++;
    end
  endtask

  task automatic test_single_block();
    clear_model();
    for (int i = 0; i < 25; i++) begin ld_push = 1; ld_data = 64'h100 + 64'(i); tick(); end
    ld_push = 0;
    ntotal++;
    if (!(pushout === 1'b1 && firstout === 1'b1 && dout === 64'h100))
      $display("FAIL single_first: got push=%b first=%b dout=%h expected 1 1 100", pushout, firstout, dout);
    else npass++;
    drain(25);
    ntotal++;
    if (got_d.size() != 25) $display("FAIL single_count: got %0d expected 25", got_d.size()); else npass++;
    ntotal++;
    if (blk_sent !== 1'b1) $display("FAIL single_blk_sent: got %b expected 1", blk_sent); else npass++;
    if (got_d.size() == 25) begin
      ntotal++;
      if (got_cyc[0] != acc_cyc[24] + 1 || got_cyc[24] != got_cyc[0] + 24)
        $display("FAIL single_timing: got first=%0d last=%0d expected %0d %0d",
                 got_cyc[0], got_cyc[24], acc_cyc[24] + 1, acc_cyc[24] + 25);
      else npass++;
    end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      ntotal++;
      if (got_d[i] !== exp_q[i] || got_f[i] !== (i % 25 == 0))
        $display("FAIL single_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_f[i], exp_q[i], i % 25 == 0);
      else npass++;
    end
    repeat (3) tick();
    ntotal++;
    if (nsent != 1 || pushout !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_end: got sent=%0d push=%b busy=%b expected 1 0 0", nsent, pushout, busy);
    else npass++;
  endtask

  task automatic test_stall();
    int g = 0;
    clear_model();
    for (int i = 0; i < 25; i++) begin ld_push = 1; ld_data = 64'h100 + 64'(i); tick(); end
    ld_push = 0;
    while (got_d.size() < 7 && g < 50) begin tick(); g++; end
    stopout = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      ntotal++;
      if (pushout !== 1'b1 || dout !== 64'h107)
        $display("FAIL stall_hold%0d: got push=%b dout=%h expected 1 107", k, pushout, dout);
      else npass++;
    end
    stopout = 0;
    tick();
    ntotal++;
    if (dout !== 64'h108) $display("FAIL stall_next: got %h expected 108", dout); else npass++;
    drain(25);
    repeat (2) tick();
    ntotal++;
    if (got_d.size() != 25 || nsent != 1)
      $display("FAIL stall_count: got beats=%0d sent=%0d expected 25 1", got_d.size(), nsent);
    else npass++;
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      ntotal++;
      if (got_d[i] !== exp_q[i] || got_f[i] !== (i % 25 == 0))
        $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_f[i], exp_q[i], i % 25 == 0);
      else npass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] data [50];
    int g = 0;
    bit stop_seen = 0;
    clear_model();
    for (int i = 0; i < 50; i++) data[i] = {$urandom, $urandom};
    while (exp_q.size() < 50 && g < 300) begin
      ld_push = 1; ld_data = data[exp_q.size()];
`ifdef PERM_TX_PINGPONG_EN
      ntotal++;
      if (ld_stop !== 1'b0) $display("FAIL b2b_ld_stop: lane %0d got %b expected 0", exp_q.size(), ld_stop);
      else npass++;
`else
      if (exp_q.size() == 25 && !stop_seen) begin
        stop_seen = 1;
        ntotal++;
        if (ld_stop !== 1'b1) $display("FAIL full_ld_stop: got %b expected 1", ld_stop); else npass++;
      end
`endif
      tick(); g++;
    end
    drain(50);
    ntotal++;
    if (got_d.size() != 50 || nsent != 2)
      $display("FAIL b2b_count: got beats=%0d sent=%0d expected 50 2", got_d.size(), nsent);
    else npass++;
    if (got_d.size() == 50) begin
      ntotal++;
`ifdef PERM_TX_PINGPONG_EN
      if (got_cyc[25] != got_cyc[24] + 1)
        $display("FAIL b2b_bubble: got %0d expected %0d", got_cyc[25], got_cyc[24] + 1);
      else npass++;
`else
      if (acc_cyc[25] != got_cyc[24] + 1)
        $display("FAIL full_holdoff: got %0d expected %0d", acc_cyc[25], got_cyc[24] + 1);
      else npass++;
`endif
    end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      ntotal++;
      if (got_d[i] !== exp_q[i] || got_f[i] !== (i % 25 == 0))
        $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_f[i], exp_q[i], i % 25 == 0);
      else npass++;
    end
  endtask

  task automatic test_random();
    bit prev_stall = 0;
    logic [63:0] prev_dout = '0;
    int g = 0;
    clear_model();
    while (got_d.size() < 100 && g < 3000) begin
      if (prev_stall) begin
        ntotal++;
        if (pushout !== 1'b1 || dout !== prev_dout)
          $display("FAIL rand_hold: got push=%b dout=%h expected 1 %h", pushout, dout, prev_dout);
        else npass++;
      end
      ld_push = (exp_q.size() < 100) && ($urandom_range(0, 9) < 7);
      ld_data = {$urandom, $urandom};
      stopout = ($urandom_range(0, 9) < 3);
      prev_stall = pushout && stopout;
      prev_dout = dout;
      tick(); g++;
    end
    ld_push = 0; stopout = 0;
    repeat (2) tick();
    ntotal++;
    if (got_d.size() != 100 || nsent != 4 || busy !== 1'b0)
      $display("FAIL rand_count: got beats=%0d sent=%0d busy=%b expected 100 4 0", got_d.size(), nsent, busy);
    else npass++;
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      ntotal++;
      if (got_d[i] !== exp_q[i] || got_f[i] !== (i % 25 == 0))
        $display("FAIL rand_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_f[i], exp_q[i], i % 25 == 0);
      else npass++;
    end
  endtask

  task automatic test_reset_mid_send();
    int g = 0;
    clear_model();
    for (int i = 0; i < 25; i++) begin ld_push = 1; ld_data = {$urandom, $urandom}; tick(); end
    ld_push = 0;
    while (got_d.size() < 12 && g < 50) begin tick(); g++; end
    #2 rst = 1; #1;
    ntotal++;
    if ({pushout, firstout, ld_stop, blk_sent, busy} !== 5'b0 || dout !== 64'h0)
      $display("FAIL midreset_out: got %b dout=%h expected 00000 0", {pushout, firstout, ld_stop, blk_sent, busy}, dout);
    else npass++;
    @(negedge clk); rst = 0; clear_model();
    for (int i = 0; i < 25; i++) begin ld_push = 1; ld_data = 64'h300 + 64'(i); tick(); end
    drain(25);
    ntotal++;
    if (got_d.size() != 25 || nsent != 1)
      $display("FAIL midreset_count: got beats=%0d sent=%0d expected 25 1", got_d.size(), nsent);
    else npass++;
    for (int i = 0; i < got_d.size(); i++) begin
      ntotal++;
      if (got_d[i] !== 64'h300 + 64'(i) || got_f[i] !== (i == 0))
        $display("FAIL midreset_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_f[i], 64'h300 + 64'(i), i == 0);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
